pre_if_stage: RTL

PRE_IF_STAGE -- requirements
Module: pre_if_stage

---
 rtl/pre_if_stage.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/pre_if_stage.sv
// Pre-fetch stage: generates the next fetch PC, issues the instruction SRAM
// request and buffers the returned word until the fetch stage takes the entry.
module pre_if_stage #(
    parameter logic [31:0] RESET_PC = 32'hbfc00000,
    parameter logic [31:0] EX_ENTRY = 32'hbfc00380
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fs_allowin,
    input  logic        fs_valid_o,
    input  logic        fs_inst_waiting,
    input  logic        fs_inst_unable,
    input  logic [32:0] br_bus,
    input  logic        ws_ex,
    input  logic        ws_eret,
    input  logic [31:0] cp0_epc,
    output logic        inst_sram_req,
    output logic        inst_sram_wr,
    output logic [1:0]  inst_sram_size,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic        inst_sram_addr_ok,
    input  logic        inst_sram_data_ok,
    input  logic [31:0] inst_sram_rdata,
    output logic        pfs_to_fs_valid,
    output logic [64:0] pfs_to_fs_bus
);

    logic        pfs_valid_q, pfs_valid_d;
    logic [31:0] pfs_pc_q, pfs_pc_d;
    logic        addr_acc_q, addr_acc_d;
    logic        inst_buf_valid_q, inst_buf_valid_d;
    logic [31:0] inst_buf_q, inst_buf_d;
    logic        br_pend_q, br_pend_d;
    logic [31:0] br_pend_pc_q, br_pend_pc_d;
    logic [1:0]  discard_cnt_q, discard_cnt_d;

    logic        pfs_valid;
    logic        flush;
    logic [31:0] flush_pc;
    logic        br_taken;
    logic [31:0] br_target;
    logic        misaligned;
    logic        addr_hs;
    logic        pfs_ready_go;
    logic        pfs_leave;
    logic        drop;
    logic        capture;
    logic        fs_took;
    logic        cancel;
    logic        delay_br;
    logic        pfs_pend;
    logic        fs_pend;
    logic [31:0] next_pc;
    logic [2:0]  cnt_sum;
    logic        unused_fs_unable;

    assign unused_fs_unable = fs_inst_unable;

    // The entry register resets to a live RESET_PC entry; gating with reset
    // keeps it invisible while reset is held.
    assign pfs_valid    = pfs_valid_q && !reset;
    assign flush        = ws_ex || ws_eret;
    assign flush_pc     = ws_ex ? EX_ENTRY : cp0_epc;
    assign br_taken     = br_bus[32];
    assign br_target    = br_bus[31:0];
    assign misaligned   = pfs_pc_q[1:0] != 2'b00;

    assign inst_sram_req   = pfs_valid && !addr_acc_q && !misaligned
                             && !flush && discard_cnt_q == 2'd0;
    assign inst_sram_wr    = 1'b0;
    assign inst_sram_size  = 2'b10;
    assign inst_sram_addr  = pfs_pc_q;
    assign inst_sram_wdata = 32'h0;

    assign addr_hs         = inst_sram_req && inst_sram_addr_ok;
    assign pfs_ready_go    = addr_acc_q || misaligned;
    assign pfs_to_fs_valid = pfs_valid && pfs_ready_go && !flush;
    assign pfs_leave       = pfs_to_fs_valid && fs_allowin;

    assign pfs_to_fs_bus = {inst_buf_valid_q || misaligned,
                            misaligned ? 32'h0 : inst_buf_q,
                            pfs_pc_q};

    // Returned words go to pending discards first, then to the fetch stage.
    assign drop    = inst_sram_data_ok && discard_cnt_q != 2'd0;
    assign fs_took = inst_sram_data_ok && discard_cnt_q == 2'd0
                     && fs_inst_waiting;
    assign capture = inst_sram_data_ok && discard_cnt_q == 2'd0
                     && !fs_inst_waiting && addr_acc_q && !inst_buf_valid_q;

    assign cancel   = pfs_valid && br_taken && fs_valid_o
                      && !flush && !pfs_leave;
    assign delay_br = br_taken && !fs_valid_o;

    assign pfs_pend = (addr_acc_q && !inst_buf_valid_q && !capture) || addr_hs;
    assign fs_pend  = fs_inst_waiting && !fs_took;

    always_comb begin
        next_pc = pfs_pc_q + 32'd4;
        if (br_taken) begin
            next_pc = br_target;
        end else if (br_pend_q) begin
            next_pc = br_pend_pc_q;
        end
    end

    always_comb begin
        pfs_valid_d      = 1'b1;
        pfs_pc_d         = pfs_pc_q;
        addr_acc_d       = addr_acc_q || addr_hs;
        inst_buf_valid_d = inst_buf_valid_q || capture;
        inst_buf_d       = capture ? inst_sram_rdata : inst_buf_q;
        br_pend_d        = br_pend_q;
        br_pend_pc_d     = br_pend_pc_q;
        if (delay_br) begin
            br_pend_d    = 1'b1;
            br_pend_pc_d = br_target;
        end
        if (flush) begin
            pfs_pc_d         = flush_pc;
            addr_acc_d       = 1'b0;
            inst_buf_valid_d = 1'b0;
            br_pend_d        = 1'b0;
        end else if (cancel || pfs_leave) begin
            pfs_pc_d         = next_pc;
            addr_acc_d       = 1'b0;
            inst_buf_valid_d = 1'b0;
            br_pend_d        = 1'b0;
        end
    end

    always_comb begin
        cnt_sum = {1'b0, discard_cnt_q} - {2'b00, drop};
        if (flush) begin
            cnt_sum = cnt_sum + {2'b00, fs_pend} + {2'b00, pfs_pend};
        end else if (cancel) begin
            cnt_sum = cnt_sum + {2'b00, pfs_pend};
        end
        discard_cnt_d = (cnt_sum > 3'd2) ? 2'd2 : cnt_sum[1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pfs_valid_q      <= 1'b1;
            pfs_pc_q         <= RESET_PC;
            addr_acc_q       <= 1'b0;
            inst_buf_valid_q <= 1'b0;
            inst_buf_q       <= 32'h0;
            br_pend_q        <= 1'b0;
            br_pend_pc_q     <= 32'h0;
            discard_cnt_q    <= 2'd0;
        end else begin
            pfs_valid_q      <= pfs_valid_d;
            pfs_pc_q         <= pfs_pc_d;
            addr_acc_q       <= addr_acc_d;
            inst_buf_valid_q <= inst_buf_valid_d;
            inst_buf_q       <= inst_buf_d;
            br_pend_q        <= br_pend_d;
            br_pend_pc_q     <= br_pend_pc_d;
            discard_cnt_q    <= discard_cnt_d;
        end
    end

endmodule
